times_five_call_arbiter: RTL and testbench

// - Round-robin arbiter sharing one exported-function call port (valid/rdy in, FIFO-read result out,
//   e.g. SimpleExportedClass TimesFive) among NUM_REQ requesters.
// - Tags each issued call with its requester ID; routes in-order results back to the issuer.
// - Sits between client logic and the exported-class instance.

---
 rtl/times_five_call_arbiter.sv | 130 +++++++++++++
 tb/tb_times_five_call_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/times_five_call_arbiter.sv
// times_five_call_arbiter: round-robin arbiter sharing one exported-function call port among NUM_REQ requesters
// Optional feature macro: ARB_STATS_EN (adds grant_count_out, per-requester saturating issue counters)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rst_and_startup_done_in  callee ready for calls; gates new issue only
//   req_valid_in/req_data_in per-requester call request and argument
//   req_rdy_out              per-requester call accepted this cycle
//   resp_valid_out           one-hot result valid toward the issuing requester
//   resp_data_out            shared result bus
//   resp_ready_in            per-requester result accept
//   fn_valid_out/fn_x_out    call toward the callee; fn_rdy_in is its accept
//   fn_rden_out              pops the callee's show-ahead result FIFO
//   fn_empty_in/fn_result_in callee result FIFO status and head
//   outstanding_out          calls issued whose result has not yet been popped
//   err_out                  sticky: callee produced a result nobody asked for
//   grant_count_out          (ARB_STATS_EN only) 32-bit issue counter per requester
module times_five_call_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int RESULT_WIDTH    = 32,
    parameter int MAX_OUTSTANDING = 16,
    localparam int IDW = $clog2(NUM_REQ),
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rst_and_startup_done_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]            req_rdy_out,
    output logic [NUM_REQ-1:0]            resp_valid_out,
    output logic [RESULT_WIDTH-1:0]       resp_data_out,
    input  logic [NUM_REQ-1:0]            resp_ready_in,
    output logic                          fn_valid_out,
    output logic [DATA_WIDTH-1:0]         fn_x_out,
    input  logic                          fn_rdy_in,
    output logic                          fn_rden_out,
    input  logic                          fn_empty_in,
    input  logic [RESULT_WIDTH-1:0]       fn_result_in,
    output logic [CW-1:0]                 outstanding_out,
    output logic                          err_out
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         grant_count_out
`endif
);
    localparam int AW = $clog2(MAX_OUTSTANDING);

    logic [IDW-1:0]          r_ptr;
    logic [IDW-1:0]          r_tag [MAX_OUTSTANDING];
    logic [AW-1:0]           r_wp;
    logic [AW-1:0]           r_rp;
    logic [CW-1:0]           r_cnt;
    logic                    r_hv;
    logic [IDW-1:0]          r_hid;
    logic [RESULT_WIDTH-1:0] r_hd;
    logic                    r_err;
    logic [IDW-1:0]          w_g;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_ack;

    // Scan downward so the last hit is the nearest valid requester at or after r_ptr.
    always_comb begin
        w_g = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid_in[(int'(r_ptr) + k) % NUM_REQ]) w_g = IDW'((int'(r_ptr) + k) % NUM_REQ);
    end

    assign w_full          = r_cnt == CW'(MAX_OUTSTANDING);
    assign w_empty         = r_cnt == '0;
    // Gating with rst keeps the call port quiet while reset is held.
    assign fn_valid_out    = |req_valid_in & !w_full & rst_and_startup_done_in & !rst;
    assign w_issue         = fn_valid_out & fn_rdy_in;
    assign fn_x_out        = req_data_in[w_g*DATA_WIDTH +: DATA_WIDTH];
    assign req_rdy_out     = w_issue ? NUM_REQ'(1) << w_g : '0;
    assign w_ack           = r_hv & resp_ready_in[r_hid];
    // Pop when the hold register is free or being emptied this same cycle.
    assign w_pop           = !fn_empty_in & !w_empty & (!r_hv | resp_ready_in[r_hid]);
    assign fn_rden_out     = w_pop;
    assign resp_valid_out  = r_hv ? NUM_REQ'(1) << r_hid : '0;
    assign resp_data_out   = r_hd;
    assign outstanding_out = r_cnt;
    assign err_out         = r_err;

    always_ff @(posedge clk) begin
        if (w_issue) r_tag[r_wp] <= w_g;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_hv  <= 1'b0;
            r_hid <= '0;
            r_hd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_ptr <= (int'(w_g) + 1 == NUM_REQ) ? '0 : w_g + 1'b1;
                r_wp  <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp  <= r_rp + 1'b1;
                r_hd  <= fn_result_in;
                r_hid <= r_tag[r_rp];
                r_hv  <= 1'b1;
            end else if (w_ack) begin
                r_hv  <= 1'b0;
            end
            r_cnt <= r_cnt + CW'(w_issue) - CW'(w_pop);
            if (!fn_empty_in & w_empty) r_err <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [31:0] r_gc;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_gc <= '0;
            else if (w_issue && w_g == IDW'(i) && r_gc != '1) r_gc <= r_gc + 1'b1;
        end
        assign grant_count_out[i*32 +: 32] = r_gc;
    end
`endif
endmodule

// File: tb/tb_times_five_call_arbiter.sv
// tb_times_five_call_arbiter: randomized and directed scoreboard bench with a TimesFive callee model
module tb_times_five_call_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int MO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              startup;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_rdy_out;
    logic [N-1:0]      resp_valid_out;
    logic [RW-1:0]     resp_data_out;
    logic [N-1:0]      resp_ready;
    logic              fn_valid_out;
    logic [DW-1:0]     fn_x_out;
    logic              fn_rdy;
    logic              fn_rden_out;
    logic              fn_empty;
    logic [RW-1:0]     fn_result;
    logic [4:0]        outstanding_out;
    logic              err_out;

    times_five_call_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst), .rst_and_startup_done_in(startup),
        .req_valid_in(req_valid), .req_data_in(req_data), .req_rdy_out(req_rdy_out),
        .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out), .resp_ready_in(resp_ready),
        .fn_valid_out(fn_valid_out), .fn_x_out(fn_x_out), .fn_rdy_in(fn_rdy),
        .fn_rden_out(fn_rden_out), .fn_empty_in(fn_empty), .fn_result_in(fn_result),
        .outstanding_out(outstanding_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [RW-1:0] d;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [RW-1:0] cq[$];
    logic [RW-1:0] pend[$];
    int            grants[$];
    int            mptr = 0;
    int            mcnt = 0;
    bit            merr = 0;
    bit            show = 1;
    bit            force_empty = 0;
    bit            inject = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic update_fn();
        fn_empty  = inject ? 1'b0 : force_empty ? 1'b1 : !(cq.size() > 0 && show);
        fn_result = cq.size() > 0 ? cq[0] : 32'hdead_beef;
    endtask

    // One clock: check the call/return ports against the spec rules, then let the callee react.
    task automatic step();
        int           g;
        bit           ev;
        bit           iss;
        bit           er;
        logic [N-1:0] e;
        logic [DW-1:0] x;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
        ev  = (req_valid != 0) && mcnt < MO && startup;
        iss = ev && fn_rdy;
        e   = '0;
        if (iss) e[g] = 1'b1;
        chk("fn_valid", fn_valid_out, ev);
        chk("req_rdy", req_rdy_out, e);
        if (ev) chk("fn_x", fn_x_out, req_data[g*DW +: DW]);
        er = !fn_empty && mcnt > 0 && (resp_valid_out == 0 || (resp_valid_out & resp_ready) != 0);
        chk("fn_rden", fn_rden_out, er);
        chk("outstanding", outstanding_out, mcnt);
        chk("err", err_out, merr);
        if (!fn_empty && mcnt == 0) merr = 1;
        if (iss) begin
            x = req_data[g*DW +: DW];
            sb.push_back('{g, x * 5});
            pend.push_back(fn_x_out * 5);
            grants.push_back(g);
            mptr = (g + 1) % N;
        end
        if (er) void'(cq.pop_front());
        mcnt += int'(iss) - int'(er);
        @(posedge clk);
        #1;
        while (pend.size() > 0) cq.push_back(pend.pop_front());
        update_fn();
    endtask

    task automatic check_reset();
        chk("rst req_rdy", req_rdy_out, 0);
        chk("rst fn_valid", fn_valid_out, 0);
        chk("rst fn_rden", fn_rden_out, 0);
        chk("rst resp_valid", resp_valid_out, 0);
        chk("rst resp_data", resp_data_out, 0);
        chk("rst outstanding", outstanding_out, 0);
        chk("rst err", err_out, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        sb.delete(); cq.delete(); pend.delete(); grants.delete();
        mptr = 0; mcnt = 0; merr = 0;
        show = 1; force_empty = 0; inject = 0;
        update_fn();
        check_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        req_valid = '0; resp_ready = '1; show = 1; force_empty = 0; inject = 0;
        update_fn();
        while ((mcnt != 0 || sb.size() != 0) && c < 300) begin
            step();
            c++;
        end
        chk("drain done", c < 300, 1);
        chk("drain outstanding", outstanding_out, 0);
    endtask

    task automatic wait_grants(input int n, input string nm);
        int c = 0;
        while (grants.size() < n && c < 200) begin
            step();
            c++;
        end
        chk(nm, grants.size() >= n, 1);
    endtask

    // Monitor: every presented result is compared with the oldest expected response.
    always @(negedge clk) begin
        if (!rst && resp_valid_out != 0) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_unexpected: got valid %b with nothing expected", resp_valid_out);
            end else begin
                chk("resp_onehot", resp_valid_out, 64'(1) << sb[0].id);
                if ((resp_valid_out & resp_ready) != 0) begin
                    chk("resp_data", resp_data_out, sb[0].d);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int            n;
        logic [RW-1:0] d0;
        rst = 1'b1; startup = 1'b0; req_valid = '0; req_data = '0;
        resp_ready = '1; fn_rdy = 1'b1;
        update_fn();
        #12 check_reset();
        @(posedge clk);
        #1 rst = 1'b0; startup = 1'b1;

        // Requester 0 alone issues 0..9.
        for (int x = 0; x < 10; x++) begin
            req_valid = 4'b0001;
            req_data[0 +: DW] = DW'(x);
            wait_grants(x + 1, "t1 issue");
        end
        drain();

        // All requesters valid: strict rotation.
        do_reset();
        req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
        wait_grants(12, "t2 issue");
        req_valid = '0;
        for (int i = 0; i < 12; i++) chk("t2 order", grants[i], i % N);
        drain();

        // Callee stalled: nothing granted, pointer held, pointer owner served first.
        do_reset();
        req_valid = 4'b0010;
        wait_grants(1, "t3 setup");
        fn_rdy = 1'b0; req_valid = 4'b1110;
        n = grants.size();
        repeat (4) step();
        chk("t3 no grant", grants.size() - n, 0);
        fn_rdy = 1'b1;
        wait_grants(n + 1, "t3 release");
        chk("t3 first", grants[n], 2);
        drain();

        // Tag FIFO full: issue stops, a single pop lets exactly one more in.
        do_reset();
        force_empty = 1; update_fn();
        req_valid = 4'b0001;
        repeat (20) step();
        chk("t4 outstanding", outstanding_out, MO);
        chk("t4 fn_valid", fn_valid_out, 0);
        force_empty = 0; update_fn();
        n = grants.size();
        step();
        force_empty = 1; update_fn();
        repeat (5) step();
        chk("t4 one more", grants.size() - n, 1);
        chk("t4 full again", outstanding_out, MO);
        drain();

        // Requester 2 withholds ready: result held stable, no pop; release pops without a bubble.
        do_reset();
        resp_ready = 4'b1011; req_valid = 4'b0100;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
        wait_grants(3, "t5 issue");
        req_valid = '0;
        n = 0;
        while (resp_valid_out == 0 && n < 20) begin
            step();
            n++;
        end
        d0 = resp_data_out;
        repeat (5) begin
            step();
            chk("t5 stable", resp_data_out, d0);
            chk("t5 held valid", resp_valid_out, 4'b0100);
            chk("t5 no rden", fn_rden_out, 0);
        end
        resp_ready = '1;
        #1 chk("t5 no bubble", fn_rden_out, 1);
        drain();

        // Spurious result with nothing outstanding.
        do_reset();
        inject = 1; update_fn();
        step();
        step();
        chk("t6 err", err_out, 1);
        chk("t6 no rden", fn_rden_out, 0);
        inject = 0; update_fn();

        // Random traffic, then reset mid-burst, then random traffic again.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            repeat (400) begin
                req_valid  = N'($urandom);
                for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
                fn_rdy     = $urandom_range(0, 3) != 0;
                resp_ready = N'($urandom);
                show       = $urandom_range(0, 3) != 0;
                update_fn();
                step();
            end
        end
        fn_rdy = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
